// File: rtl/naes_pkg.sv
// Shared definitions for the NES-style CPU/PPU glue blocks.
package naes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG = 16'h4014;
  localparam int unsigned OAM_SIZE    = 256;

endpackage : naes_pkg

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to $4014 latches a source page, then the engine
// stalls the CPU and copies $PP00-$PPFF into OAM one byte every two cycles.
module oam_dma_ctrl
  import naes_pkg::*;
#(
  parameter logic [15:0] DMA_REG  = OAM_DMA_REG,
  parameter int unsigned XFER_LEN = OAM_SIZE
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_wr,
  input  logic        odd_or_even,
  output logic        hijack,
  output logic [15:0] dma_bus_addr,
  output logic        dma_bus_wr,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_en
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q,  page_d;
  logic [7:0] idx_q,   idx_d;
  logic [7:0] data_q,  data_d;
  logic       extra_q, extra_d;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      extra_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      extra_q <= extra_d;
    end
  end

  // Next-state and datapath update: trigger, alignment stall, read/write pairs.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    extra_d = extra_q;
    unique case (state_q)
      IDLE: begin
        if (bus_addr == DMA_REG && !bus_wr) begin
          page_d  = bus_din;
          idx_d   = '0;
          extra_d = odd_or_even;
          state_d = ALIGN;
        end
      end
      ALIGN: begin
        // An odd-cycle trigger spends one extra dummy cycle here.
        if (extra_q) begin
          extra_d = 1'b0;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        data_d  = bus_din;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = (idx_q == LAST_IDX) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded only from registered state, never from bus inputs.
  always_comb begin
    hijack       = (state_q != IDLE);
    dma_bus_wr   = 1'b1;
    dma_bus_addr = '0;
    oam_addr     = idx_q;
    oam_data     = '0;
    oam_en       = 1'b0;
    unique case (state_q)
      READ:  dma_bus_addr = {page_q, idx_q};
      WRITE: begin
        oam_data = data_q;
        oam_en   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule : oam_dma_ctrl

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl with a transfer-level reference model.
module tb_oam_dma_ctrl;

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_wr;
  logic        odd_or_even;
  logic        hijack;
  logic [15:0] dma_bus_addr;
  logic        dma_bus_wr;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_en;

  logic [7:0]  cpu_data;
  logic        cpu_drive;
  logic [7:0]  key;

  int checks   = 0;
  int failures = 0;

  oam_dma_ctrl dut (
    .cpu_clk      (cpu_clk),
    .reset        (reset),
    .bus_addr     (bus_addr),
    .bus_din      (bus_din),
    .bus_wr       (bus_wr),
    .odd_or_even  (odd_or_even),
    .hijack       (hijack),
    .dma_bus_addr (dma_bus_addr),
    .dma_bus_wr   (dma_bus_wr),
    .oam_addr     (oam_addr),
    .oam_data     (oam_data),
    .oam_en       (oam_en)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Zero-wait memory: byte at address a is a[7:0] ^ key.
  function automatic logic [7:0] mem_rd(input logic [15:0] a, input logic [7:0] k);
    return a[7:0] ^ k;
  endfunction

  always_comb bus_din = cpu_drive ? cpu_data : mem_rd(dma_bus_addr, key);

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == 16'h4014) a = 16'h0000;
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues a trigger at the current negedge and follows the whole transfer.
  // retrig_t >= 0: rewrite $4014 in the first WRITE cycle at/after that cycle.
  // rst_t >= 0: assert reset in that cycle and check the abort.
  // Returns on the negedge where hijack is first seen low again.
  task automatic run_xfer(input logic [7:0] page, input logic par,
                          input int retrig_t, input int rst_t);
    int          t;
    int          hi_len, en_n, first_en, consec, wr_bad, ord_bad, rd_bad, img_bad;
    logic        prev_en, retrig_done, done;
    logic [15:0] prev_addr;
    logic [15:0] rlog [256];
    logic [7:0]  img  [256];
    hi_len = 0; en_n = 0; first_en = -1; consec = 0; wr_bad = 0; ord_bad = 0;
    prev_en = 1'b0; retrig_done = 1'b0; done = 1'b0; prev_addr = '0;

    bus_addr    = 16'h4014;
    bus_wr      = 1'b0;
    cpu_data    = page;
    odd_or_even = par;
    cpu_drive   = 1'b1;
    @(negedge cpu_clk);
    bus_addr    = rand_addr();
    bus_wr      = 1'($urandom);
    cpu_drive   = 1'b0;
    odd_or_even = 1'($urandom);
    chk("hijack_rise", 32'(hijack), 32'd1);

    t = 0;
    while (t < 600 && !done) begin
      if (t > 0) @(negedge cpu_clk);
      if (cpu_drive) begin
        bus_addr  = rand_addr();
        bus_wr    = 1'b1;
        cpu_drive = 1'b0;
      end
      if (rst_t >= 0 && t == rst_t + 1) begin
        chk("rst_hijack", 32'(hijack), 32'd0);
        chk("rst_oam_en", 32'(oam_en), 32'd0);
        reset = 1'b0;
        done  = 1'b1;
      end else if (!hijack) begin
        done = 1'b1;
      end else begin
        hi_len++;
        if (dma_bus_wr !== 1'b1) wr_bad++;
        if (oam_en) begin
          if (prev_en) consec++;
          if (first_en < 0) first_en = t;
          if (en_n < 256) begin
            rlog[en_n] = prev_addr;
            if (oam_addr !== 8'(en_n)) ord_bad++;
            img[oam_addr] = oam_data;
          end
          en_n++;
        end
        prev_en   = oam_en;
        prev_addr = dma_bus_addr;
        if (rst_t >= 0 && t == rst_t) reset = 1'b1;
        if (retrig_t >= 0 && t >= retrig_t && oam_en && !retrig_done) begin
          bus_addr    = 16'h4014;
          bus_wr      = 1'b0;
          cpu_data    = page ^ 8'h01;
          cpu_drive   = 1'b1;
          retrig_done = 1'b1;
        end
      end
      t++;
    end

    if (!done) begin
      chk("timeout", 32'd0, 32'd1);
    end else if (rst_t < 0) begin
      rd_bad = 0; img_bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (rlog[i] !== {page, 8'(i)}) rd_bad++;
        if (img[i] !== mem_rd({page, 8'(i)}, key)) img_bad++;
      end
      chk("hijack_len",   32'(hi_len),   32'(513 + int'(par)));
      chk("oam_en_count", 32'(en_n),     32'd256);
      chk("first_en",     32'(first_en), 32'(2 + int'(par)));
      chk("en_consec",    32'(consec),   32'd0);
      chk("bus_wr_bad",   32'(wr_bad),   32'd0);
      chk("oam_addr_ord", 32'(ord_bad),  32'd0);
      chk("read_addr",    32'(rd_bad),   32'd0);
      chk("last_read",    32'(rlog[255]), 32'({page, 8'hFF}));
      chk("oam_image",    32'(img_bad),  32'd0);
      chk("idle_bus_addr", 32'(dma_bus_addr), 32'd0);
      chk("idle_oam_data", 32'(oam_data),     32'd0);
      chk("idle_oam_en",   32'(oam_en),       32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge cpu_clk);
  endtask

  initial begin
    reset       = 1'b1;
    bus_addr    = 16'h4014;
    bus_wr      = 1'b0;
    cpu_data    = 8'h55;
    cpu_drive   = 1'b1;
    odd_or_even = 1'b0;
    key         = 8'hA5;
    repeat (3) @(negedge cpu_clk);
    // Reset dominates a simultaneous $4014 write.
    chk("reset_hijack",   32'(hijack),       32'd0);
    chk("reset_oam_en",   32'(oam_en),       32'd0);
    chk("reset_oam_addr", 32'(oam_addr),     32'd0);
    chk("reset_oam_data", 32'(oam_data),     32'd0);
    chk("reset_bus_addr", 32'(dma_bus_addr), 32'd0);
    chk("reset_bus_wr",   32'(dma_bus_wr),   32'd1);
    reset     = 1'b0;
    bus_addr  = 16'h0000;
    bus_wr    = 1'b1;
    cpu_drive = 1'b0;
    idle(2);
    chk("idle_after_reset", 32'(hijack), 32'd0);

    run_xfer(8'h02, 1'b0, -1, -1);   idle(3);
    run_xfer(8'h02, 1'b1, -1, -1);   idle(2);
    run_xfer(8'h02, 1'b0, 100, -1);  idle(4);
    key = 8'h3C;
    run_xfer(8'hFF, 1'b0, -1, -1);   idle(2);
    run_xfer(8'($urandom), 1'($urandom), -1, 300);
    key = 8'($urandom);
    run_xfer(8'h04, 1'b0, -1, -1);
    // Back-to-back: second trigger in the first cycle after hijack falls.
    run_xfer(8'($urandom), 1'b1, -1, -1);
    for (int n = 0; n < 3; n++) begin
      key = 8'($urandom);
      idle(int'($urandom_range(1, 5)));
      run_xfer(8'($urandom), 1'($urandom),
               ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(10, 480)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_oam_dma_ctrl

// File: doc/oam_dma_ctrl.md
# oam_dma_ctrl

Sprite-DMA engine between the CPU bus and the PPU's OAM port. A CPU write to $4014 latches a source page. The engine then stalls the CPU via `hijack` and drives the bus itself, copying 256 bytes from $PP00–$PPFF into OAM indices 0–255. It feeds the PPU's sprite RAM write port (address, data, enable), which the PPU selects while `hijack` is high.

## Interface
- `DMA_REG`, 16'h4014, CPU address that triggers a transfer
- `XFER_LEN`, 256, bytes per transfer; must be a power of two, ≤256
- `cpu_clk`  in  1  system CPU clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; clock `cpu_clk`
- `bus_addr`  in  16  CPU bus address
- `bus_din`  in  8  CPU bus data: write data on CPU writes, memory read data during DMA reads
- `bus_wr`  in  1  bus direction: 1 = read cycle, 0 = write cycle
- `odd_or_even`  in  1  CPU cycle parity; 1 = odd cycle
- `hijack`  out  1  CPU stalled, DMA owns the bus
- `dma_bus_addr`  out  16  address driven onto the CPU bus while `hijack` is high
- `dma_bus_wr`  out  1  direction driven while `hijack` is high; always 1 (read)
- `oam_addr`  out  8  OAM write index
- `oam_data`  out  8  OAM write data
- `oam_en`  out  1  OAM write strobe, one cycle per byte

## Operation
- **Trigger:** a write to $4014 is a posedge where `bus_addr==DMA_REG`, `bus_wr==0` and state is IDLE.
  - On trigger, latch `page<=bus_din` and `idx<=0`.
  - Latch `extra<=odd_or_even`.
  - Go to ALIGN.
- **States:**
  - IDLE: `hijack=0`, `oam_en=0`.
  - ALIGN: dummy cycle.
    - If `extra==1`, clear it and stay one more cycle.
    - Otherwise go to READ.
  - READ: drive `dma_bus_addr={page,idx}` with `dma_bus_wr=1`.
    - At the closing edge, `data<=bus_din`.
    - Go to WRITE.
  - WRITE: drive `oam_addr=idx`, `oam_data=data`, `oam_en=1`.
    - At the closing edge, `idx<=idx+1`.
    - If `idx==XFER_LEN-1`, go to IDLE; otherwise go to READ.
- **Arithmetic:** `idx` is 8-bit; the increment wraps modulo 256 and is never observed past 255. The source address is a plain concatenation, so page $FF reads $FF00–$FFFF with no carry.
- **Re-trigger:** writes to $4014 while not IDLE are ignored; `page` is unchanged.
- **CPU writes to OAM:** not this block's concern. The PPU muxes OAM address and enable on `hijack`.
- **Outputs outside READ/WRITE:** `dma_bus_addr=0` and `oam_data=0`.

## Timing
- **Reset values:**
  - State IDLE; `hijack=0`, `oam_en=0`, `oam_addr=0`, `oam_data=0`.
  - `dma_bus_addr=0`, `dma_bus_wr=1`.
  - `page=0`, `idx=0`, `extra=0`.
- **Latency:**
  - `hijack` rises the cycle after the trigger edge.
  - Even trigger: `hijack` stays high for exactly 1+2·XFER_LEN cycles (513).
  - Odd trigger: `hijack` stays high for exactly 2+2·XFER_LEN cycles (514).
- **Write pattern:** first `oam_en` comes 2 or 3 cycles after `hijack` rises. `oam_en` pulses every second cycle and is never asserted on consecutive cycles.
- **Read timing:** read data must be valid on `bus_din` at the rising edge that ends each READ cycle (zero-wait memory).
- **End of transfer:** `hijack` falls on the edge after the final WRITE. A trigger in that same next cycle is accepted.
- **Reset mid-transfer:** on the next edge, go to IDLE with `hijack=0` and `oam_en=0`. A partial OAM image remains.
- **Outputs:** all outputs are registered or decoded purely from state registers; none depend combinationally on bus inputs.

## Structure
- Shared package `naes_pkg` holds:
  - `dma_state_t` enum: IDLE, ALIGN, READ, WRITE.
  - `localparam OAM_DMA_REG = 16'h4014`.
  - `localparam OAM_SIZE = 256`.
- Single module with no sub-module. Datapath: page register, index counter, data latch, state register.

## Test plan
- **Even trigger:** reset, CPU write $4014←$02 with `odd_or_even=0`, memory model returns `addr[7:0]^8'hA5`.
  - `hijack` high exactly 513 cycles.
  - 256 `oam_en` pulses; OAM[i] == i^$A5.
  - Reads span $0200–$02FF in order.
- **Odd trigger:** same stimulus with `odd_or_even=1`.
  - `hijack` high exactly 514 cycles.
  - First READ address $0200 occurs 2 cycles after `hijack` rises.
- **Re-trigger while busy:** write $4014←$03 at DMA cycle 100.
  - Ignored; all reads stay in page $02.
  - Total length unchanged.
- **Page wrap:** $4014←$FF.
  - Last read address $FFFF.
  - `hijack` falls cleanly with no carry into the page.
- **Reset mid-transfer:** assert `reset` at cycle 300 of a transfer.
  - Next cycle `hijack=0` and `oam_en=0`.
  - A subsequent $4014←$04 runs a full, correct 513-cycle transfer.
- **Back-to-back:** new trigger on the first cycle after `hijack` falls is accepted.
  - `hijack` rises one cycle later.
